branch_predictor: RTL and testbench

Parametrised dynamic next-PC predictor for the pipelined RV32I core. It replaces the static "PC+4 unless resolved" next-PC selection with a direct-mapped branch target buffer (BTB) and a gshare pattern history table (PHT).

- The fetch stage queries it combinationally every cycle.
- The execute stage trains it with each resolved control-flow instruction.
- It keeps saturating performance counters for branches and mispredictions.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> branch predictor bus.
//   f_pc, pred_taken, pred_next_pc : combinational fetch lookup
//   u_*                            : one resolved control-flow op per cycle
//   branch_cnt, mispred_cnt        : saturating performance counters
// master = core side (fetch + execute), slave = predictor.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  f_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_next_pc;
    logic             u_valid;
    logic [XLEN-1:0]  u_pc;
    logic             u_is_branch;
    logic             u_is_jump;
    logic             u_taken;
    logic [XLEN-1:0]  u_target;
    logic             u_mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_taken, u_target, u_mispredict,
        input  pred_taken, pred_next_pc, branch_cnt, mispred_cnt
    );
    modport slave (
        input  f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_taken, u_target, u_mispredict,
        output pred_taken, pred_next_pc, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic next-PC predictor: direct-mapped BTB + gshare PHT.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bp    - branch_predictor_if.slave (lookup, update, perf counters)
// Lookup is purely combinational from f_pc and registered state; updates
// land on the rising edge and are visible the following cycle (no bypass).
module branch_predictor #(
    parameter int XLEN         = 32,
    parameter int BTB_IDX_BITS = 4,
    parameter int GHR_BITS     = 4,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int PHT_N = 1 << GHR_BITS;
    localparam int TAG_W = XLEN - BTB_IDX_BITS - 2;

    logic [BTB_N-1:0]      btb_valid;
    logic [BTB_N-1:0]      btb_jump;
    logic [TAG_W-1:0]      btb_tag [BTB_N];
    logic [XLEN-1:0]       btb_tgt [BTB_N];
    logic [PHT_N-1:0][1:0] pht;
    logic [GHR_BITS-1:0]   ghr;
    logic [CNT_W-1:0]      branch_cnt;
    logic [CNT_W-1:0]      mispred_cnt;

    // Instructions are word aligned; the low PC bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.f_pc[1:0], bp.u_pc[1:0]};

    // ---------------- lookup ----------------
    logic [BTB_IDX_BITS-1:0] bi;
    logic [GHR_BITS-1:0]     pi;
    logic [TAG_W-1:0]        f_tag;
    logic                    hit;

    assign bi    = bp.f_pc[BTB_IDX_BITS+1:2];
    assign pi    = bp.f_pc[GHR_BITS+1:2] ^ ghr;
    assign f_tag = bp.f_pc[XLEN-1:BTB_IDX_BITS+2];
    // valid bits are cleared asynchronously, so this is already 0 in reset;
    // the explicit reset term just makes that obvious.
    assign hit   = reset && btb_valid[bi] && (btb_tag[bi] == f_tag);

    assign bp.pred_taken   = hit && (btb_jump[bi] || pht[pi][1]);
    assign bp.pred_next_pc = bp.pred_taken ? btb_tgt[bi] : bp.f_pc + XLEN'(4);

    // ---------------- update ----------------
    logic [BTB_IDX_BITS-1:0] ui;
    logic [GHR_BITS-1:0]     upi;
    logic [TAG_W-1:0]        u_tag;
    logic                    is_br;
    logic                    alloc;

    assign ui    = bp.u_pc[BTB_IDX_BITS+1:2];
    assign upi   = bp.u_pc[GHR_BITS+1:2] ^ ghr;
    assign u_tag = bp.u_pc[XLEN-1:BTB_IDX_BITS+2];
    assign is_br = bp.u_valid && bp.u_is_branch && !bp.u_is_jump;
    // Not-taken branches never allocate or invalidate an entry.
    assign alloc = bp.u_valid && (bp.u_is_jump || (bp.u_is_branch && bp.u_taken));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid   <= '0;
            btb_jump    <= '0;
            pht         <= {PHT_N{2'b01}};
            ghr         <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (alloc) begin
                btb_valid[ui] <= 1'b1;
                btb_jump[ui]  <= bp.u_is_jump;
            end
            if (is_br) begin
                if (bp.u_taken) begin
                    if (pht[upi] != 2'd3) pht[upi] <= pht[upi] + 2'd1;
                end else begin
                    if (pht[upi] != 2'd0) pht[upi] <= pht[upi] - 2'd1;
                end
                // shift in the outcome; truncation drops the oldest bit
                ghr <= GHR_BITS'({ghr, bp.u_taken});
            end
            if (bp.u_valid && bp.u_is_branch && branch_cnt != {CNT_W{1'b1}})
                branch_cnt <= branch_cnt + 1'b1;
            if (bp.u_valid && bp.u_mispredict && mispred_cnt != {CNT_W{1'b1}})
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    // Tag/target payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (reset && alloc) begin
            btb_tag[ui] <= u_tag;
            btb_tgt[ui] <= bp.u_target;
        end
    end

    assign bp.branch_cnt  = branch_cnt;
    assign bp.mispred_cnt = mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. CNT_W is shrunk to 4 so counter
// saturation (15) is reachable in a few cycles; other parameters default.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .CNT_W(4)) bpi ();
    branch_predictor #(.XLEN(32), .BTB_IDX_BITS(4), .GHR_BITS(4), .CNT_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bpi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_u();
        bpi.u_valid = 0; bpi.u_pc = '0; bpi.u_is_branch = 0; bpi.u_is_jump = 0;
        bpi.u_taken = 0; bpi.u_target = '0; bpi.u_mispredict = 0;
    endtask

    // One update, sampled by the next rising edge; returns at edge+1.
    task automatic upd(input logic [31:0] pc, input logic br, input logic jp,
                       input logic tk, input logic mp, input logic [31:0] tgt);
        bpi.u_valid = 1; bpi.u_pc = pc; bpi.u_is_branch = br; bpi.u_is_jump = jp;
        bpi.u_taken = tk; bpi.u_mispredict = mp; bpi.u_target = tgt;
        @(posedge clk); #1;
        clr_u();
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_nxt);
        bpi.f_pc = pc; #1;
        chk({tag, "_tk"},  {31'd0, bpi.pred_taken}, {31'd0, exp_tk});
        chk({tag, "_nxt"}, bpi.pred_next_pc, exp_nxt);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 0; bpi.f_pc = 32'h100; clr_u();

        // ---- reset defaults ----
        #2;
        chk("rst_tk",  {31'd0, bpi.pred_taken}, 32'd0);
        chk("rst_nxt", bpi.pred_next_pc, 32'h104);
        chk("rst_bc",  {28'd0, bpi.branch_cnt}, 32'd0);
        chk("rst_mc",  {28'd0, bpi.mispred_cnt}, 32'd0);
        @(negedge clk); reset = 1;
        repeat (2) @(posedge clk); #1;
        look("idle", 32'h100, 0, 32'h104);
        chk("idle_bc", {28'd0, bpi.branch_cnt}, 32'd0);
        look("wrap", 32'hFFFF_FFFC, 0, 32'h0);

        // ---- branch learning ----
        // 0x40: BTB index 0, PHT base 0. After one taken update GHR=0001, so
        // the next lookup indexes PHT[1] (still weakly not-taken) even though
        // the BTB now hits and PHT[0] has moved to 2.
        upd(32'h40, 1, 0, 1, 0, 32'h80);
        chk("b1_ghr",  {28'd0, dut.ghr}, 32'h1);
        chk("b1_pht0", {30'd0, dut.pht[0]}, 32'd2);
        look("b1", 32'h40, 0, 32'h44);
        upd(32'h40, 1, 0, 0, 0, 32'h80);
        chk("b2_ghr",  {28'd0, dut.ghr}, 32'h2);
        chk("b2_pht1", {30'd0, dut.pht[1]}, 32'd0);
        chk("b2_bc",   {28'd0, bpi.branch_cnt}, 32'd2);

        // ---- saturation / hysteresis ----
        // Seven taken updates of 0x40: the first four walk GHR 0->1->3->7->F,
        // after which GHR is pinned at F and the last three all hit PHT[F].
        do_reset();
        for (int i = 0; i < 4; i++) upd(32'h40, 1, 0, 1, 0, 32'h80);
        chk("s_ghr", {28'd0, dut.ghr}, 32'hF);
        for (int i = 0; i < 3; i++) upd(32'h40, 1, 0, 1, 0, 32'h80);
        chk("s_phtF", {30'd0, dut.pht[15]}, 32'd3);
        chk("s_bc",   {28'd0, bpi.branch_cnt}, 32'd7);
        look("s_hit", 32'h40, 1, 32'h80);
        upd(32'h40, 1, 0, 0, 0, 32'h80);
        chk("h_phtF", {30'd0, dut.pht[15]}, 32'd2);
        chk("h_bit",  {31'd0, dut.pht[15][1]}, 32'd1);
        chk("h_ghr",  {28'd0, dut.ghr}, 32'hE);
        chk("h_bc",   {28'd0, bpi.branch_cnt}, 32'd8);
        look("h_newidx", 32'h40, 0, 32'h44);   // PHT[E] still 1

        // ---- jump and alias (index 4) ----
        upd(32'h10, 0, 1, 0, 0, 32'h200);      // u_taken ignored for jumps
        look("j10", 32'h10, 1, 32'h200);
        look("a50", 32'h50, 0, 32'h54);
        upd(32'h50, 0, 1, 1, 0, 32'h300);
        look("j50", 32'h50, 1, 32'h300);
        look("j10m", 32'h10, 0, 32'h14);
        chk("j_ghr", {28'd0, dut.ghr}, 32'hE);
        chk("j_bc",  {28'd0, bpi.branch_cnt}, 32'd8);
        // neither branch nor jump: only the mispredict counter moves
        upd(32'h80, 0, 0, 1, 1, 32'h999);
        chk("n_ghr", {28'd0, dut.ghr}, 32'hE);
        chk("n_mc",  {28'd0, bpi.mispred_cnt}, 32'd1);
        look("n_btb", 32'h80, 0, 32'h84);

        // ---- same-cycle hazard ----
        do_reset();
        bpi.f_pc = 32'h40;
        bpi.u_valid = 1; bpi.u_pc = 32'h40; bpi.u_is_jump = 1; bpi.u_taken = 1;
        bpi.u_target = 32'h80;
        #1;
        chk("hz_old_tk",  {31'd0, bpi.pred_taken}, 32'd0);
        chk("hz_old_nxt", bpi.pred_next_pc, 32'h44);
        @(posedge clk); #1; clr_u(); #1;
        chk("hz_new_tk",  {31'd0, bpi.pred_taken}, 32'd1);
        chk("hz_new_nxt", bpi.pred_next_pc, 32'h80);

        // ---- async reset mid-run ----
        for (int i = 0; i < 5; i++) upd(32'h0, 0, 0, 0, 1, 32'h0);
        bpi.u_mispredict = 1;                   // without u_valid: ignored
        @(posedge clk); #1; bpi.u_mispredict = 0;
        chk("ar_mc5", {28'd0, bpi.mispred_cnt}, 32'd5);
        look("ar_pre", 32'h40, 1, 32'h80);
        @(negedge clk); #2;
        reset = 0; #1;                          // no rising edge in between
        chk("ar_tk",  {31'd0, bpi.pred_taken}, 32'd0);
        chk("ar_nxt", bpi.pred_next_pc, 32'h44);
        chk("ar_mc",  {28'd0, bpi.mispred_cnt}, 32'd0);
        bpi.u_valid = 1; bpi.u_pc = 32'h40; bpi.u_is_jump = 1; bpi.u_target = 32'h80;
        bpi.u_mispredict = 1;
        @(posedge clk); #1;
        chk("ar_in_mc", {28'd0, bpi.mispred_cnt}, 32'd0);
        chk("ar_in_tk", {31'd0, bpi.pred_taken}, 32'd0);
        clr_u();
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        look("ar_post", 32'h40, 0, 32'h44);
        chk("ar_post_mc", {28'd0, bpi.mispred_cnt}, 32'd0);

        // ---- counter saturation (CNT_W=4) ----
        for (int i = 0; i < 20; i++) upd(32'h40, 1, 0, 0, 1, 32'h0);
        chk("sat_bc", {28'd0, bpi.branch_cnt}, 32'd15);
        chk("sat_mc", {28'd0, bpi.mispred_cnt}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
